if_fetch_stage: RTL

//  Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC, issues requests to a

---
 rtl/if_pkg.sv | 17 +
 rtl/if_hold_buf.sv | 37 +++
 rtl/if_fetch_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and default constants for the instruction-fetch stage.
package if_pkg;

    // FETCH: request outstanding at pc
    // HOLD : word captured under freeze, no request
    // DRAIN: request outstanding whose result will be thrown away
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam int unsigned WIDTH_DEFAULT    = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INC_DEFAULT      = 32'd4;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry hold register for a word fetched while the pipeline is frozen.
module if_hold_buf #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] hold_d;

    // Load wins over clear; the controller never asserts both together.
    always_comb begin
        hold_d = hold_q;
        if (load) begin
            hold_d = d;
        end else if (clear) begin
            hold_d = '0;
        end
    end

    // Hold register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign q = hold_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks req/ready to instruction
// memory, applies EXE redirects and ID freezes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | request at pc outstanding; word delivered when ready
// ST_HOLD  | word fetched under freeze is held and re-presented
// ST_DRAIN | redirect arrived mid-request; finish it, discard the word
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int unsigned      WIDTH    = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
    parameter logic [WIDTH-1:0] INC      = WIDTH'(INC_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_addr,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] Instruction,
    output logic             fetch_valid
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] branch_tgt;
    logic [WIDTH-1:0] hold_word;
    logic             hold_load;
    logic             hold_clear;

    assign pc_inc     = pc_q + INC;
    // Instructions are word aligned, so the low two target bits are dropped.
    assign branch_tgt = branch_addr & ~WIDTH'(3);
    assign imem_addr  = pc_q;

    if_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (hold_load),
        .clear (hold_clear),
        .d     (imem_rdata),
        .q     (hold_word)
    );

    // Next-state, next-pc and redirect bookkeeping; a redirect always wins.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pending_d  = pending_q;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (branch_taken) begin
                    if (imem_ready) begin
                        pc_d = branch_tgt;
                    end else begin
                        pending_d = branch_tgt;
                        state_d   = ST_DRAIN;
                    end
                end else if (imem_ready) begin
                    if (freeze) begin
                        hold_load = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    pc_d       = branch_tgt;
                    hold_clear = 1'b1;
                    state_d    = ST_FETCH;
                end else if (!freeze) begin
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (branch_taken) begin
                    pending_d = branch_tgt;
                    if (imem_ready) begin
                        pc_d    = branch_tgt;
                        state_d = ST_FETCH;
                    end
                end else if (imem_ready) begin
                    pc_d    = pending_q;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State, pc and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
        end
    end

    // Memory request and delivered-instruction outputs; zeros when not valid.
    always_comb begin
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        PC          = '0;
        Instruction = '0;
        if (!rst) begin
            imem_req = (state_q != ST_HOLD);
            if (!branch_taken) begin
                if (state_q == ST_FETCH && imem_ready) begin
                    fetch_valid = 1'b1;
                    PC          = pc_inc;
                    Instruction = imem_rdata;
                end else if (state_q == ST_HOLD) begin
                    fetch_valid = 1'b1;
                    PC          = pc_inc;
                    Instruction = hold_word;
                end
            end
        end
    end

endmodule
